// File: rtl/pipe_stage_regs_pkg.sv
// Shared widths, control-bundle bit positions and pipeline-register layouts
// for the front-end pipeline register bank.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 3;
    localparam int CTRL_W = 12;

    localparam logic [XLEN-1:0] RESET_PC  = '0;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int RESULTSRC0_BIT = 0;
    localparam int REGWRITE_BIT   = 1;
    localparam int MEMWRITE_BIT   = 2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
    } ifid_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   immExt;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcPlus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    // A flushed IF/ID slot looks exactly like the reset state: a NOP that is not valid.
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pcPlus4: '0};
    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Hazard-control and datapath signals shared between the pipeline register
// bank (slave) and the surrounding fetch/decode logic plus hazard unit (master).
interface pipe_stage_regs_if;
    import pipe_pkg::*;

    logic              StallF, StallD, FlushD, FlushE;
    logic [XLEN-1:0]   PCNextF, InstrF, PCPlus4F;
    logic [XLEN-1:0]   RD1D, RD2D, ImmExtD;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic [CTRL_W-1:0] CtrlD;

    logic [XLEN-1:0]   PCF;
    logic [XLEN-1:0]   InstrD, PCD, PCPlus4D;
    logic              ValidD;
    logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [CTRL_W-1:0] CtrlE;
    logic              ResultSrcE0;
    logic              ValidE;

    modport slave (
        input  StallF, StallD, FlushD, FlushE,
        input  PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, CtrlD,
        output PCF, InstrD, PCD, PCPlus4D, ValidD,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, CtrlE,
        output ResultSrcE0, ValidE
    );

    modport master (
        output StallF, StallD, FlushD, FlushE,
        output PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, CtrlD,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, CtrlE,
        input  ResultSrcE0, ValidE
    );

endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register: clear beats enable, asynchronous active-high reset.
module pipe_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= RST_VAL;
        else if (clr)
            data_q <= CLR_VAL;
        else if (en)
            data_q <= d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers obeying the hazard unit's stall/flush
// controls, plus saturating stall/flush/bubble event counters for profiling.
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_regs_if.slave      bus,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] pc_q;
    ifid_t           ifId_d, ifId_q;
    idex_t           idEx_d, idEx_q;

    pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pcReg (
        .clk(clk), .rst(rst), .en(!bus.StallF), .clr(1'b0), .d(bus.PCNextF), .q(pc_q)
    );

    assign ifId_d = '{valid: 1'b1, instr: bus.InstrF, pc: pc_q, pcPlus4: bus.PCPlus4F};

    pipe_reg #(.W($bits(ifid_t)), .RST_VAL(IFID_BUBBLE), .CLR_VAL(IFID_BUBBLE)) u_ifIdReg (
        .clk(clk), .rst(rst), .en(!bus.StallD), .clr(bus.FlushD), .d(ifId_d), .q(ifId_q)
    );

    // Decode operands come straight from the decode stage; only valid/PC fields come from IF/ID.
    assign idEx_d = '{valid:   ifId_q.valid,
                      rd1:     bus.RD1D,
                      rd2:     bus.RD2D,
                      immExt:  bus.ImmExtD,
                      pc:      ifId_q.pc,
                      pcPlus4: ifId_q.pcPlus4,
                      rs1:     bus.Rs1D,
                      rs2:     bus.Rs2D,
                      rd:      bus.RdD,
                      ctrl:    bus.CtrlD};

    pipe_reg #(.W($bits(idex_t)), .RST_VAL(IDEX_BUBBLE), .CLR_VAL(IDEX_BUBBLE)) u_idExReg (
        .clk(clk), .rst(rst), .en(1'b1), .clr(bus.FlushE), .d(idEx_d), .q(idEx_q)
    );

    assign bus.PCF         = pc_q;
    assign bus.InstrD      = ifId_q.instr;
    assign bus.PCD         = ifId_q.pc;
    assign bus.PCPlus4D    = ifId_q.pcPlus4;
    assign bus.ValidD      = ifId_q.valid;
    assign bus.RD1E        = idEx_q.rd1;
    assign bus.RD2E        = idEx_q.rd2;
    assign bus.ImmExtE     = idEx_q.immExt;
    assign bus.PCE         = idEx_q.pc;
    assign bus.PCPlus4E    = idEx_q.pcPlus4;
    assign bus.Rs1E        = idEx_q.rs1;
    assign bus.Rs2E        = idEx_q.rs2;
    assign bus.RdE         = idEx_q.rd;
    assign bus.CtrlE       = idEx_q.ctrl;
    assign bus.ResultSrcE0 = idEx_q.ctrl[RESULTSRC0_BIT];
    assign bus.ValidE      = idEx_q.valid;

    logic [CNT_W-1:0] stallCnt_d, stallCnt_q;
    logic [CNT_W-1:0] flushCnt_d, flushCnt_q;
    logic [CNT_W-1:0] bubbleCnt_d, bubbleCnt_q;

    // Counters stick at all-ones rather than wrapping so a long profile never under-reports.
    always_comb begin
        stallCnt_d  = stallCnt_q;
        flushCnt_d  = flushCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        if (bus.StallF && stallCnt_q != CNT_MAX)
            stallCnt_d = stallCnt_q + CNT_W'(1);
        if (bus.FlushD && flushCnt_q != CNT_MAX)
            flushCnt_d = flushCnt_q + CNT_W'(1);
        if (bus.FlushE && bubbleCnt_q != CNT_MAX)
            bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            bubbleCnt_q <= '0;
        end else begin
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign stall_cnt  = stallCnt_q;
    assign flush_cnt  = flushCnt_q;
    assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed, table-driven bench for the front-end pipeline register bank,
// with hand sequences for asynchronous reset and counter saturation.
module tb_pipe_stage_regs;
    import pipe_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] stallCnt, flushCnt, bubbleCnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_regs_if ifc ();

    pipe_stage_regs #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc),
        .stall_cnt(stallCnt),
        .flush_cnt(flushCnt),
        .bubble_cnt(bubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stallF, stallD, flushD, flushE;
        logic [31:0] pcNext, instr, pcP4;
        logic [2:0]  rd;
        logic [11:0] ctrl;
        logic [31:0] expPcf, expInstrD, expPcD, expP4D;
        logic        expVD, expVE;
        logic [2:0]  expRdE;
        logic [11:0] expCtrlE;
        int          expStall, expFlush, expBubble;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        ifc.StallF   = v.stallF;
        ifc.StallD   = v.stallD;
        ifc.FlushD   = v.flushD;
        ifc.FlushE   = v.flushE;
        ifc.PCNextF  = v.pcNext;
        ifc.InstrF   = v.instr;
        ifc.PCPlus4F = v.pcP4;
        ifc.RdD      = v.rd;
        ifc.Rs1D     = v.rd + 3'd1;
        ifc.Rs2D     = v.rd + 3'd2;
        ifc.CtrlD    = v.ctrl;
        ifc.RD1D     = 32'hD000_0000 + 32'(idx);
        ifc.RD2D     = 32'hE000_0000 + 32'(idx);
        ifc.ImmExtD  = 32'hF000_0000 + 32'(idx);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " PCF"},      64'(ifc.PCF), 64'(RESET_PC));
        checkOutput({tag, " InstrD"},   64'(ifc.InstrD), 64'(32'h0000_0013));
        checkOutput({tag, " PCD"},      64'(ifc.PCD), 64'd0);
        checkOutput({tag, " ValidD"},   64'(ifc.ValidD), 64'd0);
        checkOutput({tag, " ValidE"},   64'(ifc.ValidE), 64'd0);
        checkOutput({tag, " CtrlE"},    64'(ifc.CtrlE), 64'd0);
        checkOutput({tag, " RdE"},      64'(ifc.RdE), 64'd0);
        checkOutput({tag, " RD1E"},     64'(ifc.RD1E), 64'd0);
        checkOutput({tag, " stallCnt"}, 64'(stallCnt), 64'd0);
        checkOutput({tag, " flushCnt"}, 64'(flushCnt), 64'd0);
        checkOutput({tag, " bubbleCnt"}, 64'(bubbleCnt), 64'd0);
    endtask

    initial begin
        // stF stD flD flE  pcNext   instr        pcP4     rd    ctrl  | PCF      InstrD       PCD      P4D    VD  VE  RdE  CtrlE  st fl bu
        vecs[0]  = '{0,0,0,0, 32'h04, 32'h1000, 32'h04, 3'd1, 12'h001, 32'h04, 32'h1000, 32'h00, 32'h04, 1, 0, 3'd1, 12'h001, 0, 0, 0};
        vecs[1]  = '{0,0,0,0, 32'h08, 32'h1004, 32'h08, 3'd2, 12'h0F0, 32'h08, 32'h1004, 32'h04, 32'h08, 1, 1, 3'd2, 12'h0F0, 0, 0, 0};
        vecs[2]  = '{0,0,0,0, 32'h0C, 32'h1008, 32'h0C, 3'd3, 12'h003, 32'h0C, 32'h1008, 32'h08, 32'h0C, 1, 1, 3'd3, 12'h003, 0, 0, 0};
        vecs[3]  = '{0,0,0,0, 32'h10, 32'h100C, 32'h10, 3'd4, 12'h801, 32'h10, 32'h100C, 32'h0C, 32'h10, 1, 1, 3'd4, 12'h801, 0, 0, 0};
        vecs[4]  = '{1,1,0,1, 32'h14, 32'h000A, 32'h14, 3'd5, 12'h7FF, 32'h10, 32'h100C, 32'h0C, 32'h10, 1, 0, 3'd0, 12'h000, 1, 0, 1};
        vecs[5]  = '{0,0,0,0, 32'h14, 32'h1010, 32'h14, 3'd5, 12'h005, 32'h14, 32'h1010, 32'h10, 32'h14, 1, 1, 3'd5, 12'h005, 1, 0, 1};
        vecs[6]  = '{0,0,1,1, 32'h40, 32'h1014, 32'h18, 3'd6, 12'h006, 32'h40, 32'h0013, 32'h00, 32'h00, 0, 0, 3'd0, 12'h000, 1, 1, 2};
        vecs[7]  = '{0,0,0,0, 32'h44, 32'h2040, 32'h44, 3'd7, 12'h401, 32'h44, 32'h2040, 32'h40, 32'h44, 1, 0, 3'd7, 12'h401, 1, 1, 2};
        vecs[8]  = '{1,1,1,0, 32'h48, 32'h2044, 32'h48, 3'd2, 12'h0AA, 32'h44, 32'h0013, 32'h00, 32'h00, 0, 1, 3'd2, 12'h0AA, 2, 2, 2};
        vecs[9]  = '{0,1,0,0, 32'h48, 32'h2044, 32'h48, 3'd3, 12'h010, 32'h48, 32'h0013, 32'h00, 32'h00, 0, 0, 3'd3, 12'h010, 2, 2, 2};
        vecs[10] = '{0,0,0,0, 32'h4C, 32'h2048, 32'h4C, 3'd1, 12'h000, 32'h4C, 32'h2048, 32'h48, 32'h4C, 1, 0, 3'd1, 12'h000, 2, 2, 2};

        rst = 1'b1;
        applyStimulus('{0,0,0,0, 32'h0, 32'h0, 32'h0, 3'd0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 3'd0, 12'h0, 0, 0, 0}, 0);
        #2;
        checkResetState("reset");
        #10;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            logic [2:0] expRs1, expRs2;
            logic [31:0] expRd1;
            string tag;
            applyStimulus(vecs[i], i);
            stepCycle();
            tag    = $sformatf("row%0d", i);
            expRs1 = vecs[i].flushE ? 3'd0 : vecs[i].rd + 3'd1;
            expRs2 = vecs[i].flushE ? 3'd0 : vecs[i].rd + 3'd2;
            expRd1 = vecs[i].flushE ? 32'd0 : 32'hD000_0000 + 32'(i);
            checkOutput({tag, " PCF"},       64'(ifc.PCF), 64'(vecs[i].expPcf));
            checkOutput({tag, " InstrD"},    64'(ifc.InstrD), 64'(vecs[i].expInstrD));
            checkOutput({tag, " PCD"},       64'(ifc.PCD), 64'(vecs[i].expPcD));
            checkOutput({tag, " PCPlus4D"},  64'(ifc.PCPlus4D), 64'(vecs[i].expP4D));
            checkOutput({tag, " ValidD"},    64'(ifc.ValidD), 64'(vecs[i].expVD));
            checkOutput({tag, " ValidE"},    64'(ifc.ValidE), 64'(vecs[i].expVE));
            checkOutput({tag, " RdE"},       64'(ifc.RdE), 64'(vecs[i].expRdE));
            checkOutput({tag, " Rs1E"},      64'(ifc.Rs1E), 64'(expRs1));
            checkOutput({tag, " Rs2E"},      64'(ifc.Rs2E), 64'(expRs2));
            checkOutput({tag, " RD1E"},      64'(ifc.RD1E), 64'(expRd1));
            checkOutput({tag, " CtrlE"},     64'(ifc.CtrlE), 64'(vecs[i].expCtrlE));
            checkOutput({tag, " ResultSrcE0"}, 64'(ifc.ResultSrcE0), 64'(vecs[i].expCtrlE[0]));
            checkOutput({tag, " stallCnt"},  64'(stallCnt), 64'(vecs[i].expStall));
            checkOutput({tag, " flushCnt"},  64'(flushCnt), 64'(vecs[i].expFlush));
            checkOutput({tag, " bubbleCnt"}, 64'(bubbleCnt), 64'(vecs[i].expBubble));
        end

        // Asynchronous reset asserted between edges must take effect with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkResetState("asyncReset");
        applyStimulus('{0,0,0,0, 32'h0, 32'h0, 32'h0, 3'd0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 3'd0, 12'h0, 0, 0, 0}, 0);
        stepCycle();
        #3;
        rst = 1'b0;

        // Counter saturation: StallF held for 2^CNT_W+5 cycles.
        ifc.StallF = 1'b1;
        ifc.PCNextF = 32'h100;
        for (int c = 0; c < 14; c++) stepCycle();
        checkOutput("sat stallCnt@14", 64'(stallCnt), 64'd14);
        for (int c = 14; c < (1 << CNT_W) + 5; c++) stepCycle();
        checkOutput("sat stallCnt@21", 64'(stallCnt), 64'd15);
        checkOutput("sat PCF held", 64'(ifc.PCF), 64'(RESET_PC));
        checkOutput("sat flushCnt", 64'(flushCnt), 64'd0);
        ifc.StallF = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Front-end pipeline register bank (PC, IF/ID, ID/EX) for the pipelined CPU.
- This is the responder side of the stall/flush interface: it obeys StallF, StallD, FlushD and FlushE from the hazard unit.
- It supplies Rs1E/Rs2E/RdE/ResultSrcE0 back to the hazard unit.
- It keeps saturating event counters (stall cycles, branch flushes, injected bubbles) for energy/perf profiling.

Parameters:
- XLEN, 32, datapath and instruction width.
- REG_AW, 3, register-address width (8 architectural registers; r0 hardwired zero).
- CTRL_W, 12, width of the decoded control bundle; bit 0 is ResultSrc[0] (load select).
- CNT_W, 16, event-counter width.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 32'h00000013, instruction injected into IF/ID on flush.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID.
- FlushD  in  1  clear IF/ID.
- FlushE  in  1  clear ID/EX (bubble).
- PCNextF  in  XLEN  next-PC mux output.
- InstrF  in  XLEN  fetched instruction.
- PCPlus4F  in  XLEN  PCF+4.
- RD1D, RD2D, ImmExtD  in  XLEN  decode-stage operands.
- Rs1D, Rs2D, RdD  in  REG_AW  decode-stage register addresses.
- CtrlD  in  CTRL_W  decoded control bundle.
- PCF  out  XLEN  fetch PC.
- InstrD, PCD, PCPlus4D  out  XLEN  IF/ID contents.
- ValidD  out  1  IF/ID holds a real instruction.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  ID/EX contents.
- Rs1E, Rs2E, RdE  out  REG_AW  ID/EX register addresses.
- CtrlE  out  CTRL_W  ID/EX control bundle.
- ResultSrcE0  out  1  equals CtrlE[0].
- ValidE  out  1  ID/EX holds a real instruction.
- stall_cnt, flush_cnt, bubble_cnt  out  CNT_W  event counters.

Behaviour:
- Reset (asynchronous, effective immediately and mid-operation):
  - PCF=RESET_PC; InstrD=NOP_INSTR.
  - All other data outputs 0; ValidD=ValidE=0; all counters 0.
- PC register, per rising edge: if !StallF then PCF<=PCNextF, else hold.
- IF/ID register, priority FlushD > StallD > load:
  - Flush: InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0.
  - Load: capture InstrF/PCF/PCPlus4F, ValidD=1.
  - Stall: hold all fields.
- ID/EX register:
  - FlushE: all fields 0, so CtrlE=0 (no RegWrite, no MemWrite) and Rs1E=Rs2E=RdE=0. r0 is excluded from forwarding, so a bubble never matches.
  - Otherwise capture all D-stage fields, ValidE=ValidD.
  - No stall input on this stage.
- Latency: one cycle per stage. D-stage data appears on E outputs the edge after capture.
- Simultaneous StallD and FlushD (load-use and taken branch together): flush wins; IF/ID becomes a bubble.
- StallF with FlushD: PC still holds. The branch target is the hazard unit's problem, since PCSrcE has no StallF interaction.
- Counters, each saturating at 2^CNT_W-1 (no wrap):
  - stall_cnt increments each cycle StallF=1.
  - flush_cnt increments each cycle FlushD=1.
  - bubble_cnt increments each cycle FlushE=1.
- No combinational path from inputs to outputs except ResultSrcE0=CtrlE[0], which is registered.

Decomposition:
- Shared package pipe_pkg holds XLEN, REG_AW, CTRL_W, NOP_INSTR, the CtrlD bit-position constants (RESULTSRC0_BIT=0, REGWRITE_BIT, MEMWRITE_BIT) and RESET_PC.
- Sub-module pipe_reg: generic width-parameterised register with en, clr and CLR_VAL, async active-high reset.
  - Instantiated for PC (clr tied 0), IF/ID and ID/EX.
- Counters are written inline.

Test Plan:
- Reset then 4 free-running cycles with PCNextF=PCPlus4F=PCF+4 -> PCF 0,4,8,12; ValidD=1 from cycle 2; ValidE=1 from cycle 3.
- Load-use: StallF=StallD=FlushE=1 for 1 cycle with InstrF=0xA -> PCF and InstrD hold; next cycle CtrlE=0, RdE=0, ValidE=0; stall_cnt=1, bubble_cnt=1.
- Taken branch: FlushD=FlushE=1 with PCNextF=0x40 -> next cycle PCF=0x40, InstrD=0x00000013, ValidD=0, ValidE=0; flush_cnt=1.
- StallD=1 and FlushD=1 together -> InstrD=NOP_INSTR and ValidD=0, not the held value.
- Assert rst mid-stream between edges -> all outputs return immediately to reset values with no clock edge; PCF=RESET_PC.
- Hold StallF=1 for 2^CNT_W+5 cycles (CNT_W overridden to 4) -> stall_cnt sticks at 15.
